// File: rtl/uart_tx_fifo_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_fifo_reader                                                        |
// | Drains a 1-cycle-latency TX FIFO and serialises each word as a UART frame. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_tx_fifo_reader #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_WIDTH + 1);

  localparam logic [CW-1:0] c_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] c_DATA_LAST = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] c_STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic          c_ODD       = (PARITY_ODD != 0);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_FETCH  = 3'd1;
  localparam logic [2:0] c_START  = 3'd2;
  localparam logic [2:0] c_DATA   = 3'd3;
  localparam logic [2:0] c_PARITY = 3'd4;
  localparam logic [2:0] c_STOP   = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;

  logic w_bit_end;
  logic w_last_stop;

  assign w_bit_end   = (cnt_q == c_BIT_LAST);
  assign w_last_stop = (state_q == c_STOP) && w_bit_end && (idx_q == c_STOP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= c_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // tx is registered, so every branch sets up the level of the following bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = w_bit_end ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    case (state_q)
      c_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        tx_d  = 1'b1;
        if (fifo_rd_en) state_d = c_FETCH;
      end
      c_FETCH: begin
        cnt_d   = '0;
        shreg_d = fifo_rd_data;
        par_d   = (^fifo_rd_data) ^ c_ODD;
        tx_d    = 1'b0;
        state_d = c_START;
      end
      c_START: begin
        if (w_bit_end) begin
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
          idx_d   = '0;
          state_d = c_DATA;
        end
      end
      c_DATA: begin
        if (w_bit_end) begin
          if (idx_q == c_DATA_LAST) begin
            idx_d = '0;
            if (PARITY_EN != 0) begin
              tx_d    = par_q;
              state_d = c_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = c_STOP;
            end
          end else begin
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      c_PARITY: begin
        if (w_bit_end) begin
          tx_d    = 1'b1;
          idx_d   = '0;
          state_d = c_STOP;
        end
      end
      c_STOP: begin
        tx_d = 1'b1;
        if (w_bit_end) begin
          if (idx_q == c_STOP_LAST) begin
            done_d  = 1'b1;
            idx_d   = '0;
            state_d = fifo_rd_en ? c_FETCH : c_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = c_IDLE;
      end
    endcase
  end

  always_comb begin
    fifo_rd_en = 1'b0;
    busy       = (state_q != c_IDLE);
    if (!rst && !fifo_empty && ((state_q == c_IDLE) || w_last_stop)) fifo_rd_en = 1'b1;
  end

  assign tx      = tx_q;
  assign tx_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_tx_fifo_reader                                                     |
// | Four framings share one FIFO model; a serial decoder feeds a scoreboard.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_uart_tx_fifo_reader;

  localparam int CPB = 4;
  // Per-unit framing: u0 8N1, u1 8E1, u2 8O1, u3 8N2.
  localparam logic [3:0] PEN  = 4'b0110;
  localparam logic [3:0] PODD = 4'b0100;
  localparam logic [3:0] NS2  = 4'b1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] fifo_empty, fifo_rd_en, tx, busy, tx_done;
  logic [7:0] rd_data [4] = '{default: 8'h00};
  logic [7:0] mem [4][16];
  int         wp [4] = '{default: 0};
  int         rp [4] = '{default: 0};
  int         n_cmp = 0;
  int         n_err = 0;
  int         bad_rd = 0;
  logic [7:0] sbq0[$], sbq1[$], sbq2[$], sbq3[$];
  logic       lastpar [4] = '{default: 1'b0};

  typedef struct {int first; int last; logic tx; logic busy; logic rd; logic done;} seg_t;
  typedef struct {int unit; logic [7:0] word; logic exp_par; logic has_par; int exp_done;} vec_t;

  always #5 clk = ~clk;

  uart_tx_fifo_reader #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty[0]), .fifo_rd_en(fifo_rd_en[0]),
    .fifo_rd_data(rd_data[0]), .tx(tx[0]), .busy(busy[0]), .tx_done(tx_done[0]));
  uart_tx_fifo_reader #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty[1]), .fifo_rd_en(fifo_rd_en[1]),
    .fifo_rd_data(rd_data[1]), .tx(tx[1]), .busy(busy[1]), .tx_done(tx_done[1]));
  uart_tx_fifo_reader #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty[2]), .fifo_rd_en(fifo_rd_en[2]),
    .fifo_rd_data(rd_data[2]), .tx(tx[2]), .busy(busy[2]), .tx_done(tx_done[2]));
  uart_tx_fifo_reader #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut3 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty[3]), .fifo_rd_en(fifo_rd_en[3]),
    .fifo_rd_data(rd_data[3]), .tx(tx[3]), .busy(busy[3]), .tx_done(tx_done[3]));

  // FIFO model: read data appears the cycle after the pop.
  always_comb begin
    for (int k = 0; k < 4; k++) fifo_empty[k] = (wp[k] == rp[k]);
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (fifo_rd_en[k] && !fifo_empty[k]) begin
        rd_data[k] <= mem[k][rp[k] % 16];
        rp[k]      <= rp[k] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) if (fifo_rd_en[k] && fifo_empty[k]) bad_rd++;
  end

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h (t=%0t)", nm, idx, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input logic [7:0] w);
    mem[k][wp[k] % 16] = w;
    wp[k] = wp[k] + 1;
    case (k)
      0: sbq0.push_back(w);
      1: sbq1.push_back(w);
      2: sbq2.push_back(w);
      default: sbq3.push_back(w);
    endcase
  endtask

  task automatic sb_pop(input int k, output logic [7:0] w, output logic ok);
    ok = 1'b1;
    w  = 8'h00;
    case (k)
      0: if (sbq0.size() > 0) w = sbq0.pop_front(); else ok = 1'b0;
      1: if (sbq1.size() > 0) w = sbq1.pop_front(); else ok = 1'b0;
      2: if (sbq2.size() > 0) w = sbq2.pop_front(); else ok = 1'b0;
      default: if (sbq3.size() > 0) w = sbq3.pop_front(); else ok = 1'b0;
    endcase
  endtask

  // Expected line level 'off' cycles after the pop cycle of a single frame.
  function automatic logic model_tx(input logic [7:0] w, input int off, input logic pen, input logic podd);
    int s;
    if (off <= 1) return 1'b1;
    s = (off - 2) / CPB;
    if (s == 0) return 1'b0;
    if (s <= 8) return w[s-1];
    if (s == 9 && pen) return (^w) ^ podd;
    return 1'b1;
  endfunction

  task automatic check_seq(input int k, input logic [7:0] w0, input logic [7:0] w1, input int n, output int done_c);
    int L, P, j, off;
    logic e_tx, e_busy, e_done, e_rd;
    L = 1 + 8 + int'(PEN[k]) + (NS2[k] ? 2 : 1);
    P = L * CPB + 1;
    done_c = -1;
    for (int c = 0; c <= n * P + 4; c++) begin
      @(negedge clk);
      if (c == 0) e_tx = 1'b1;
      else begin
        j    = (c - 1) / P;
        off  = c - j * P;
        e_tx = (j >= n) ? 1'b1 : model_tx((j == 0) ? w0 : w1, off, PEN[k], PODD[k]);
      end
      e_busy = (c >= 1) && (c <= n * P);
      e_done = (c > 1) && ((c - 1) % P == 0) && ((c - 1) / P <= n);
      e_rd   = (c % P == 0) && (c / P < n);
      chk("seq_tx", c, tx[k], e_tx);
      chk("seq_busy", c, busy[k], e_busy);
      chk("seq_done", c, tx_done[k], e_done);
      chk("seq_rd_en", c, fifo_rd_en[k], e_rd);
      if (tx_done[k] && done_c < 0) done_c = c;
    end
  endtask

  task automatic wait_n(input int n, output logic ab);
    ab = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rst) begin
        ab = 1'b1;
        return;
      end
    end
  endtask

  // Mid-bit sampling decoder; a frame cut by reset is dropped unchecked.
  task automatic rx_loop(input int k);
    logic [7:0] d, e;
    logic st, p, sp, ab, a1, ok;
    forever begin
      @(negedge clk);
      while (rst || tx[k] !== 1'b0) @(negedge clk);
      d = 8'h00; p = 1'b0; sp = 1'b1;
      wait_n(2, ab);
      st = tx[k];
      for (int i = 0; i < 8; i++) if (!ab) begin wait_n(CPB, a1); ab |= a1; d[i] = tx[k]; end
      if (PEN[k] && !ab) begin wait_n(CPB, a1); ab |= a1; p = tx[k]; end
      for (int s = 0; s < (NS2[k] ? 2 : 1); s++) if (!ab) begin wait_n(CPB, a1); ab |= a1; sp &= tx[k]; end
      if (!ab) begin
        sb_pop(k, e, ok);
        chk("rx_expected_word", k, ok, 1'b1);
        chk("rx_start", k, st, 1'b0);
        chk("rx_data", k, d, e);
        if (PEN[k]) begin
          chk("rx_parity", k, p, (^e) ^ PODD[k]);
          lastpar[k] = p;
        end
        chk("rx_stop", k, sp, 1'b1);
      end
    end
  endtask

  initial rx_loop(0);
  initial rx_loop(1);
  initial rx_loop(2);
  initial rx_loop(3);

  initial begin
    seg_t segs[15];
    vec_t vecs[4];
    logic [7:0] junk;
    logic ok;
    int dc, bad_tx, bad_busy, bad_rd_en, bad_done;

    segs[0]  = '{0, 0, 1'b1, 1'b0, 1'b1, 1'b0};
    segs[1]  = '{1, 1, 1'b1, 1'b1, 1'b0, 1'b0};
    segs[2]  = '{2, 5, 1'b0, 1'b1, 1'b0, 1'b0};
    segs[3]  = '{6, 9, 1'b1, 1'b1, 1'b0, 1'b0};
    segs[4]  = '{10, 13, 1'b0, 1'b1, 1'b0, 1'b0};
    segs[5]  = '{14, 17, 1'b1, 1'b1, 1'b0, 1'b0};
    segs[6]  = '{18, 21, 1'b0, 1'b1, 1'b0, 1'b0};
    segs[7]  = '{22, 25, 1'b0, 1'b1, 1'b0, 1'b0};
    segs[8]  = '{26, 29, 1'b1, 1'b1, 1'b0, 1'b0};
    segs[9]  = '{30, 33, 1'b0, 1'b1, 1'b0, 1'b0};
    segs[10] = '{34, 37, 1'b1, 1'b1, 1'b0, 1'b0};
    segs[11] = '{38, 41, 1'b1, 1'b1, 1'b0, 1'b0};
    segs[12] = '{42, 42, 1'b1, 1'b0, 1'b0, 1'b1};
    segs[13] = '{43, 46, 1'b1, 1'b0, 1'b0, 1'b0};
    segs[14] = '{47, 47, 1'b1, 1'b0, 1'b0, 1'b0};

    vecs[0] = '{1, 8'h07, 1'b1, 1'b1, 46};
    vecs[1] = '{2, 8'h07, 1'b0, 1'b1, 46};
    vecs[2] = '{3, 8'h3C, 1'b0, 1'b0, 46};
    vecs[3] = '{0, 8'hC3, 1'b0, 1'b0, 42};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", 0, tx, 4'hF);
    chk("rst_busy", 0, busy, 4'h0);
    chk("rst_done", 0, tx_done, 4'h0);
    chk("rst_rd_en", 0, fifo_rd_en, 4'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Single 0xA5 frame, cycle-exact against the hand table
    @(posedge clk); #1 push(0, 8'hA5);
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      for (int s = 0; s < 15; s++) begin
        if (c >= segs[s].first && c <= segs[s].last) begin
          chk("a5_tx", c, tx[0], segs[s].tx);
          chk("a5_busy", c, busy[0], segs[s].busy);
          chk("a5_rd_en", c, fifo_rd_en[0], segs[s].rd);
          chk("a5_done", c, tx_done[0], segs[s].done);
        end
      end
    end

    // Back-to-back 0x00 then 0xFF
    @(posedge clk); #1 push(0, 8'h00); push(0, 8'hFF);
    check_seq(0, 8'h00, 8'hFF, 2, dc);
    chk("b2b_first_done", 0, dc, 42);
    chk("b2b_fifo_drained", 0, fifo_empty[0], 1'b1);

    // Parity / stop-bit variants from the vector table
    for (int v = 0; v < 4; v++) begin
      @(posedge clk); #1 push(vecs[v].unit, vecs[v].word);
      check_seq(vecs[v].unit, vecs[v].word, 8'h00, 1, dc);
      chk("vec_done_cycle", v, dc, vecs[v].exp_done);
      if (vecs[v].has_par) chk("vec_parity_bit", v, lastpar[vecs[v].unit], vecs[v].exp_par);
    end

    // Long idle with every FIFO empty
    bad_tx = 0; bad_busy = 0; bad_rd_en = 0; bad_done = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (tx !== 4'hF) bad_tx++;
      if (busy !== 4'h0) bad_busy++;
      if (fifo_rd_en !== 4'h0) bad_rd_en++;
      if (tx_done !== 4'h0) bad_done++;
    end
    chk("idle_tx_cycles", 0, bad_tx, 0);
    chk("idle_busy_cycles", 0, bad_busy, 0);
    chk("idle_rd_en_cycles", 0, bad_rd_en, 0);
    chk("idle_done_cycles", 0, bad_done, 0);

    // Reset during data bit 3 of 0x5A, then a clean 0x11 frame
    @(posedge clk); #1 push(0, 8'h5A);
    repeat (20) @(negedge clk);
    chk("abort_pre_busy", 0, busy[0], 1'b1);
    chk("abort_pre_tx_bit3", 0, tx[0], 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_tx", 0, tx[0], 1'b1);
    chk("abort_busy", 0, busy[0], 1'b0);
    sb_pop(0, junk, ok);
    chk("abort_sb_had_word", 0, ok, 1'b1);
    push(0, 8'h11);
    #1 chk("abort_rd_en_in_rst", 0, fifo_rd_en[0], 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_seq(0, 8'h11, 8'h00, 1, dc);
    chk("post_rst_done", 0, dc, 42);

    repeat (5) @(negedge clk);
    chk("sb_left_u0", 0, sbq0.size(), 0);
    chk("sb_left_u1", 1, sbq1.size(), 0);
    chk("sb_left_u2", 2, sbq2.size(), 0);
    chk("sb_left_u3", 3, sbq3.size(), 0);
    chk("fifo_all_empty", 0, fifo_empty, 4'hF);
    chk("rd_en_while_empty", 0, bad_rd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
